// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared pipeline definitions for the MEM/WB, control and writeback logic:
//   - RegDst / MemtoReg control encodings
//   - default link ($ra) and exception-PC ($k0) register indices
//   - instruction field slice positions and extract helpers
// -----------------------------------------------------------------------------
package wb_regfile_pkg;

  // Destination register select driven by the control unit.
  typedef enum logic [1:0] {
    REGDST_RD = 2'b00,
    REGDST_RT = 2'b01,
    REGDST_RA = 2'b10,
    REGDST_XP = 2'b11
  } regdst_e;

  // Writeback value select; both upper encodings pick PC+4.
  typedef enum logic [1:0] {
    MEMTOREG_ALU    = 2'b00,
    MEMTOREG_MEM    = 2'b01,
    MEMTOREG_PC     = 2'b10,
    MEMTOREG_PC_ALT = 2'b11
  } memtoreg_e;

  localparam int RA_IDX_DFLT = 31;
  localparam int XP_IDX_DFLT = 26;

  // Instruction field positions (5-bit register specifiers).
  localparam int REG_IDX_W = 5;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;

  function automatic logic [REG_IDX_W-1:0] instr_rt(input logic [31:0] instr);
    return instr[RT_LSB +: REG_IDX_W];
  endfunction

  function automatic logic [REG_IDX_W-1:0] instr_rd(input logic [31:0] instr);
    return instr[RD_LSB +: REG_IDX_W];
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//   Architectural register file: two combinational read ports, one write port.
//   Register 0 is hardwired to zero. A write presented in the same cycle as a
//   read of the same index is bypassed to the read port. Synchronous
//   active-high reset clears every register.
// Ports
//   clk_i, reset_i             clock, synchronous active-high reset
//   we_i, waddr_i, wdata_i     write port (commits on posedge)
//   raddr1_i/rdata1_o          read port A
//   raddr2_i/rdata2_o          read port B
// -----------------------------------------------------------------------------
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  // Entry 0 is reset to zero and never written; reads of index 0 are also
  // forced to zero below, so it can never leak a value.
  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_live_s;

  // A write is live only outside reset; this gates both commit and bypass.
  assign wr_live_s = we_i && !reset_i && (waddr_i != {AW{1'b0}});

  // Storage update: clear on reset, otherwise commit the live write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_live_s) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port A with $0 rule and same-cycle bypass.
  always_comb begin
    rdata1_o = {DATA_W{1'b0}};
    if (raddr1_i == {AW{1'b0}}) begin
      rdata1_o = {DATA_W{1'b0}};
    end else if (wr_live_s && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
    end else begin
      rdata1_o = regs_q[raddr1_i];
    end
  end

  // Read port B, identical rules to port A.
  always_comb begin
    rdata2_o = {DATA_W{1'b0}};
    if (raddr2_i == {AW{1'b0}}) begin
      rdata2_o = {DATA_W{1'b0}};
    end else if (wr_live_s && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
    end else begin
      rdata2_o = regs_q[raddr2_i];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage plus architectural register file of the 5-stage MIPS
//   pipeline. Selects destination index and writeback value from the MEM/WB
//   register, commits the write on posedge, serves the ID stage read ports
//   (with bypass), exports the committed write to the forwarding unit and
//   counts retired register writes.
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   instructionin, PCplusin,         MEM/WB pipeline register contents
//   rdatain, ALUresultin
//   RegDstin, RegWrin, MemtoRegin    MEM/WB control
//   raddr1/rdata1, raddr2/rdata2     ID-stage read ports (combinational)
//   wb_en, wb_addr, wb_data          current writeback (combinational)
//   retire_cnt                       committed register writes, wraps
// -----------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int RA_IDX = RA_IDX_DFLT,
  parameter int XP_IDX = XP_IDX_DFLT,
  parameter int CNT_W  = 32,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instructionin,
  input  logic [DATA_W-1:0] PCplusin,
  input  logic [DATA_W-1:0] rdatain,
  input  logic [DATA_W-1:0] ALUresultin,
  input  logic [1:0]        RegDstin,
  input  logic              RegWrin,
  input  logic [1:0]        MemtoRegin,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              wb_en,
  output logic [AW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic [AW-1:0]     wb_addr_s;
  logic [DATA_W-1:0] wb_data_s;
  logic              wb_en_s;
  logic [CNT_W-1:0]  retire_cnt_d;
  logic [CNT_W-1:0]  retire_cnt_q;

  // Destination index select.
  always_comb begin
    wb_addr_s = {AW{1'b0}};
    case (RegDstin)
      REGDST_RD: wb_addr_s = AW'(instr_rd(instructionin));
      REGDST_RT: wb_addr_s = AW'(instr_rt(instructionin));
      REGDST_RA: wb_addr_s = AW'(RA_IDX);
      REGDST_XP: wb_addr_s = AW'(XP_IDX);
      default:   wb_addr_s = {AW{1'b0}};
    endcase
  end

  // Writeback value select; both upper encodings return PC+4 (link value).
  always_comb begin
    wb_data_s = {DATA_W{1'b0}};
    case (MemtoRegin)
      MEMTOREG_ALU:    wb_data_s = ALUresultin;
      MEMTOREG_MEM:    wb_data_s = rdatain;
      MEMTOREG_PC:     wb_data_s = PCplusin;
      MEMTOREG_PC_ALT: wb_data_s = PCplusin;
      default:         wb_data_s = {DATA_W{1'b0}};
    endcase
  end

  // Writes to $0 are not real commits: they neither update state nor count.
  assign wb_en_s = RegWrin && (wb_addr_s != {AW{1'b0}}) && !reset;

  // Retire counter next state; wraps naturally at 2^CNT_W.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (wb_en_s) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // Retire counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_q <= {CNT_W{1'b0}};
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_rf (
    .clk_i    (clk),
    .reset_i  (reset),
    .we_i     (wb_en_s),
    .waddr_i  (wb_addr_s),
    .wdata_i  (wb_data_s),
    .raddr1_i (raddr1),
    .raddr2_i (raddr2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  assign wb_en      = wb_en_s;
  assign wb_addr    = wb_addr_s;
  assign wb_data    = wb_data_s;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//   Scoreboard bench: the driver applies one MEM/WB beat per cycle and pushes
//   the expected combinational outputs from a reference model; the monitor
//   pops and compares on the falling edge. Two DUTs share all inputs: a
//   default build and a CNT_W=4 build to exercise counter wrap.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] mdata;
    logic [31:0] alu;
    logic [1:0]  regdst;
    logic        regwr;
    logic [1:0]  m2r;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
  } stim_t;

  typedef struct {
    logic        known;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instructionin, PCplusin, rdatain, ALUresultin;
  logic [1:0]  RegDstin, MemtoRegin;
  logic        RegWrin;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, wb_data, retire_cnt;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] s_rdata1, s_rdata2, s_wb_data;
  logic        s_wb_en;
  logic [4:0]  s_wb_addr;
  logic [3:0]  s_retire_cnt;

  int n_vec = 0;
  int n_mis = 0;
  exp_t sb_q[$];

  // Reference model state.
  logic [31:0] m_regs [32];
  int unsigned m_cnt;
  logic        m_known = 1'b0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .instructionin(instructionin), .PCplusin(PCplusin),
    .rdatain(rdatain), .ALUresultin(ALUresultin), .RegDstin(RegDstin),
    .RegWrin(RegWrin), .MemtoRegin(MemtoRegin), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .retire_cnt(retire_cnt)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .instructionin(instructionin), .PCplusin(PCplusin),
    .rdatain(rdatain), .ALUresultin(ALUresultin), .RegDstin(RegDstin),
    .RegWrin(RegWrin), .MemtoRegin(MemtoRegin), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(s_rdata1), .rdata2(s_rdata2), .wb_en(s_wb_en), .wb_addr(s_wb_addr),
    .wb_data(s_wb_data), .retire_cnt(s_retire_cnt)
  );

  function automatic logic [31:0] mk_instr(input int rt, input int rd);
    return (32'(rt) << 16) | (32'(rd) << 11);
  endfunction

  // Destination per the RegDst table: rd, rt, $ra (31), $k0 (26).
  function automatic logic [4:0] m_dest(input stim_t s);
    case (s.regdst)
      2'd0:    return s.instr[15:11];
      2'd1:    return s.instr[20:16];
      2'd2:    return 5'd31;
      default: return 5'd26;
    endcase
  endfunction

  function automatic logic [31:0] m_value(input stim_t s);
    if (s.m2r == 2'd0) return s.alu;
    else if (s.m2r == 2'd1) return s.mdata;
    else return s.pc;
  endfunction

  function automatic exp_t m_expect(input stim_t s);
    exp_t e;
    e.known = m_known;
    e.addr  = m_dest(s);
    e.data  = m_value(s);
    e.en    = s.regwr && (e.addr != 5'd0) && !s.rst;
    e.rd1   = (s.ra1 == 5'd0) ? 32'd0 : ((e.en && s.ra1 == e.addr) ? e.data : m_regs[s.ra1]);
    e.rd2   = (s.ra2 == 5'd0) ? 32'd0 : ((e.en && s.ra2 == e.addr) ? e.data : m_regs[s.ra2]);
    e.cnt   = m_cnt;
    e.cnt4  = 4'(m_cnt % 16);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation, away from posedge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("wb_en",   32'(wb_en),   32'(e.en));
      check("wb_addr", 32'(wb_addr), 32'(e.addr));
      check("wb_data", wb_data,      e.data);
      check("wb_en_c4", 32'(s_wb_en), 32'(e.en));
      if (e.known) begin
        check("rdata1",     rdata1, e.rd1);
        check("rdata2",     rdata2, e.rd2);
        check("retire_cnt", retire_cnt, e.cnt);
        check("retire_cnt4", 32'(s_retire_cnt), 32'(e.cnt4));
        check("rdata1_c4",  s_rdata1, e.rd1);
      end
    end
  end

  // Apply one beat: drive, queue expectation, clock it, advance the model.
  task automatic step(input stim_t s);
    logic [4:0]  a;
    logic [31:0] v;
    logic        en;
    reset = s.rst; instructionin = s.instr; PCplusin = s.pc; rdatain = s.mdata;
    ALUresultin = s.alu; RegDstin = s.regdst; RegWrin = s.regwr; MemtoRegin = s.m2r;
    raddr1 = s.ra1; raddr2 = s.ra2;
    sb_q.push_back(m_expect(s));
    a  = m_dest(s);
    v  = m_value(s);
    en = s.regwr && (a != 5'd0) && !s.rst;
    @(posedge clk);
    if (s.rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 0;
      m_known = 1'b1;
    end else if (en) begin
      m_regs[a] = v;
      m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  function automatic stim_t idle(input int r1, input int r2);
    stim_t s;
    s = '{rst: 1'b0, instr: 32'd0, pc: 32'd0, mdata: 32'd0, alu: 32'd0,
          regdst: 2'd0, regwr: 1'b0, m2r: 2'd0, ra1: 5'(r1), ra2: 5'(r2)};
    return s;
  endfunction

  initial begin
    stim_t s;
    m_cnt = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    reset = 1'b1; instructionin = 32'd0; PCplusin = 32'd0; rdatain = 32'd0;
    ALUresultin = 32'd0; RegDstin = 2'd0; RegWrin = 1'b0; MemtoRegin = 2'd0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    @(posedge clk); #1;

    // 1: reset, then reads of 5 and 31 return zero.
    s = idle(5, 31); s.rst = 1'b1; step(s);
    s = idle(5, 31); step(s);

    // 2: ALU write to rd=8 bypassed same cycle, then read from storage.
    s = idle(8, 0); s.regwr = 1'b1; s.instr = mk_instr(0, 8); s.alu = 32'h1234_5678; step(s);
    s = idle(8, 0); step(s);

    // 3: jal link to $31, then exception PC to $26, then read both.
    s = idle(31, 0); s.regwr = 1'b1; s.regdst = 2'd2; s.m2r = 2'd2; s.pc = 32'h0040_0010; step(s);
    s = idle(26, 31); s.regwr = 1'b1; s.regdst = 2'd3; s.m2r = 2'd3; s.pc = 32'h8000_0004; step(s);
    s = idle(31, 26); step(s);

    // 4: write aimed at $0 is dropped.
    s = idle(0, 0); s.regwr = 1'b1; s.instr = mk_instr(0, 0); s.alu = 32'hFFFF_FFFF; step(s);
    s = idle(0, 8); step(s);

    // 5: load to rt=9, both ports bypass the same value.
    s = idle(9, 9); s.regwr = 1'b1; s.regdst = 2'd1; s.m2r = 2'd1;
    s.instr = mk_instr(9, 3); s.mdata = 32'hDEAD_BEEF; step(s);

    // 6: reset with a write in flight; stored reads still visible during reset.
    s = idle(9, 10); s.rst = 1'b1; s.regwr = 1'b1; s.instr = mk_instr(0, 10); s.alu = 32'hCAFE_0001; step(s);
    s = idle(9, 10); step(s);

    // Counter wrap on the CNT_W=4 build: 15 commits, then one more wraps to 0.
    for (int i = 1; i <= 16; i++) begin
      s = idle(i, 1); s.regwr = 1'b1; s.instr = mk_instr(0, i); s.alu = 32'(i * 3); step(s);
    end
    s = idle(16, 15); step(s);

    // Randomised traffic with occasional reset and biased bypass hits.
    for (int n = 0; n < 600; n++) begin
      s.rst    = ($urandom_range(0, 49) == 0);
      s.instr  = $urandom();
      s.pc     = $urandom();
      s.mdata  = $urandom();
      s.alu    = $urandom();
      s.regdst = 2'($urandom_range(0, 3));
      s.regwr  = ($urandom_range(0, 3) != 0);
      s.m2r    = 2'($urandom_range(0, 3));
      s.ra1    = 5'($urandom_range(0, 31));
      s.ra2    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) s.ra1 = m_dest(s);
      if ($urandom_range(0, 3) == 0) s.ra2 = m_dest(s);
      step(s);
    end

    s = idle(0, 0); step(s);
    @(negedge clk); #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
